// File: rtl/dut_pkg.sv
// Shared opcode names, default widths and response bundle
// for the command processor and its coverage collateral.
package dut_pkg;

   localparam int DEF_ADR_W  = 4;
   localparam int DEF_DATA_W = 4;
   localparam int DEF_CMD_W  = 4;
   localparam int DEF_DROP_W = 8;

   typedef enum logic [DEF_CMD_W-1:0] {
      C_NOP   = 4'd0,
      C_WRITE = 4'd1,
      C_READ  = 4'd2,
      C_INCR  = 4'd3,
      C_CLEAR = 4'd4
   } cmd_e;

   typedef struct packed {
      logic [DEF_ADR_W-1:0]  adr;
      logic [DEF_DATA_W-1:0] data;
      logic                  carry;
   } rsp_t;

endpackage

// File: rtl/dut_regfile.sv
// Register array: async clear on reset, one comb read port,
// one write port and a clear-by-pointer path used by the sweep.
module dut_regfile #(
   parameter int ADR_W  = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              clr,
   input  logic [ADR_W-1:0]  clr_adr,
   input  logic [ADR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADR_W];

   // Storage update; the clear sweep owns the array while active
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**ADR_W; i++) mem[i] <= '0;
      end else if (clr) begin
         mem[clr_adr] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dut_cmd_proc.sv
// Command processor: decodes one opcode per edge against the
// register file, runs the clear sweep and counts dropped commands.
module dut_cmd_proc
   import dut_pkg::*;
#(
   parameter int ADR_W  = DEF_ADR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CMD_W  = DEF_CMD_W,
   parameter int DROP_W = DEF_DROP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CMD_W-1:0]  cmd,
   input  logic [ADR_W-1:0]  adr,
   input  logic [DATA_W-1:0] data,
   output logic              rsp_valid,
   output logic [ADR_W-1:0]  rsp_adr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_carry,
   output logic              busy,
   output logic              err,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam logic [CMD_W-1:0] OP_NOP   = CMD_W'(C_NOP);
   localparam logic [CMD_W-1:0] OP_WRITE = CMD_W'(C_WRITE);
   localparam logic [CMD_W-1:0] OP_READ  = CMD_W'(C_READ);
   localparam logic [CMD_W-1:0] OP_INCR  = CMD_W'(C_INCR);
   localparam logic [CMD_W-1:0] OP_CLEAR = CMD_W'(C_CLEAR);

   typedef enum logic {S_IDLE, S_CLEAR} state_e;

   state_e            state_q, state_d;
   logic [ADR_W-1:0]  ptr_q, ptr_d;
   logic              we, clr;
   logic [DATA_W-1:0] wdata, rdata;
   logic [DATA_W:0]   sum;
   logic              rv_d, rc_d, err_d, drop_inc;
   logic [DATA_W-1:0] rd_d;

   dut_regfile #(
      .ADR_W  (ADR_W),
      .DATA_W (DATA_W)
   ) u_rf (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .waddr   (adr),
      .wdata   (wdata),
      .clr     (clr),
      .clr_adr (ptr_q),
      .raddr   (adr),
      .rdata   (rdata)
   );

   // Decode, sweep sequencing and response/drop qualification
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      we       = 1'b0;
      clr      = 1'b0;
      sum      = {1'b0, rdata} + {1'b0, data};
      wdata    = data;
      rv_d     = 1'b0;
      rd_d     = rdata;
      rc_d     = 1'b0;
      err_d    = 1'b0;
      drop_inc = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            case (cmd)
               OP_NOP: ;
               OP_WRITE: we = 1'b1;
               OP_READ: rv_d = 1'b1;
               OP_INCR: begin
                  we    = 1'b1;
                  wdata = sum[DATA_W-1:0];
                  rv_d  = 1'b1;
                  rd_d  = sum[DATA_W-1:0];
                  rc_d  = sum[DATA_W];
               end
               OP_CLEAR: begin
                  state_d = S_CLEAR;
                  ptr_d   = '0;
               end
               default: err_d = 1'b1;
            endcase
         end
         S_CLEAR: begin
            clr   = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == '1) state_d = S_IDLE;
            if (cmd != OP_NOP) drop_inc = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state and sweep pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Response register: payload holds while no response is due
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_adr   <= '0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         err       <= 1'b0;
      end else begin
         rsp_valid <= rv_d;
         err       <= err_d;
         if (rv_d) begin
            rsp_adr   <= adr;
            rsp_data  <= rd_d;
            rsp_carry <= rc_d;
         end
      end
   end

   // Saturating count of commands discarded during the sweep
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop_inc && drop_cnt != '1) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   assign busy = (state_q == S_CLEAR);

   a_cmd_known: assert property (
      @(posedge clk) disable iff (rst)
      (state_q != S_IDLE) || !$isunknown(cmd)
   );

endmodule

// File: tb/tb_dut_cmd_proc.sv
// Self-checking bench for dut_cmd_proc against a behavioural
// register-file model with directed and randomized scenarios.
module tb_dut_cmd_proc;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cmd;
   logic [3:0] adr;
   logic [3:0] data;
   logic       rsp_valid;
   logic [3:0] rsp_adr;
   logic [3:0] rsp_data;
   logic       rsp_carry;
   logic       busy;
   logic       err;
   logic [7:0] drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   int   mreg [16];
   int   mdrop;
   int   busy_left;
   logic exp_valid, exp_carry, exp_err, exp_busy;
   logic [3:0] exp_adr, exp_data;

   dut_cmd_proc dut (
      .clk       (clk),
      .rst       (rst),
      .cmd       (cmd),
      .adr       (adr),
      .data      (data),
      .rsp_valid (rsp_valid),
      .rsp_adr   (rsp_adr),
      .rsp_data  (rsp_data),
      .rsp_carry (rsp_carry),
      .busy      (busy),
      .err       (err),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mreg[i] = 0;
      mdrop = 0; busy_left = 0;
      exp_valid = 0; exp_carry = 0; exp_err = 0; exp_busy = 0;
      exp_adr = 0; exp_data = 0;
   endtask

   // Drive one command at negedge, advance model at posedge, settle
   task automatic step(input int c, input int a, input int d);
      int s;
      @(negedge clk);
      cmd = 4'(c); adr = 4'(a); data = 4'(d);
      @(posedge clk);
      exp_valid = 0; exp_err = 0;
      if (busy_left > 0) begin
         if (c != 0 && mdrop < 255) mdrop++;
         busy_left--;
      end else begin
         case (c)
            0: ;
            1: mreg[a] = d;
            2: begin
               exp_valid = 1; exp_adr = 4'(a);
               exp_data = 4'(mreg[a]); exp_carry = 0;
            end
            3: begin
               s = mreg[a] + d;
               mreg[a] = s % 16;
               exp_valid = 1; exp_adr = 4'(a);
               exp_data = 4'(s % 16); exp_carry = (s > 15);
            end
            4: begin
               for (int i = 0; i < 16; i++) mreg[i] = 0;
               busy_left = 16;
            end
            default: exp_err = 1;
         endcase
      end
      exp_busy = (busy_left > 0);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; cmd = 0; adr = 0; data = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      model_reset();
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({rsp_valid, rsp_adr, rsp_data, rsp_carry, busy, err, drop_cnt} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_state got v=%b a=%0d d=%0d c=%b b=%b e=%b drop=%0d want all 0",
                  rsp_valid, rsp_adr, rsp_data, rsp_carry, busy, err, drop_cnt);
      end
   endtask

   task automatic test_write_read();
      step(1, 3, 9);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL write_no_rsp got %b want 0", rsp_valid);
      end
      step(2, 3, 0);
      n_checks++;
      if ({rsp_valid, rsp_adr, rsp_data, rsp_carry} !== {1'b1, 4'd3, 4'd9, 1'b0}) begin
         n_fail++;
         $display("FAIL write_read got v=%b a=%0d d=%0d c=%b want v=1 a=3 d=9 c=0",
                  rsp_valid, rsp_adr, rsp_data, rsp_carry);
      end
      step(0, 0, 0);
      n_checks++;
      if ({rsp_valid, rsp_adr, rsp_data} !== {1'b0, 4'd3, 4'd9}) begin
         n_fail++;
         $display("FAIL rsp_hold got v=%b a=%0d d=%0d want v=0 a=3 d=9",
                  rsp_valid, rsp_adr, rsp_data);
      end
   endtask

   task automatic test_incr_carry();
      step(1, 5, 14);
      step(3, 5, 3);
      n_checks++;
      if ({rsp_valid, rsp_adr, rsp_data, rsp_carry} !== {1'b1, 4'd5, 4'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL incr_carry got v=%b a=%0d d=%0d c=%b want v=1 a=5 d=1 c=1",
                  rsp_valid, rsp_adr, rsp_data, rsp_carry);
      end
      step(2, 5, 0);
      n_checks++;
      if ({rsp_valid, rsp_data, rsp_carry} !== {1'b1, 4'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL incr_readback got v=%b d=%0d c=%b want v=1 d=1 c=0",
                  rsp_valid, rsp_data, rsp_carry);
      end
   endtask

   task automatic test_clear_drop();
      int busy_cycles = 0;
      int d0;
      bit fell = 0;
      d0 = int'(drop_cnt);
      step(4, 0, 0);
      if (busy) busy_cycles++;
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 7);
         if (busy) busy_cycles++;
         if (!busy && !fell) begin
            fell = 1;
            n_checks++;
            if (int'(drop_cnt) - d0 !== 16) begin
               n_fail++;
               $display("FAIL clear_drop got %0d want 16", int'(drop_cnt) - d0);
            end
         end
      end
      n_checks++;
      if (busy_cycles !== 16) begin
         n_fail++; $display("FAIL clear_busy_len got %0d want 16", busy_cycles);
      end
      for (int a = 0; a < 16; a++) begin
         step(2, a, 0);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 4'(mreg[a]) || rsp_data !== (a == 0 ? 4'd7 : 4'd0)) begin
            n_fail++;
            $display("FAIL clear_read[%0d] got v=%b d=%0d want v=1 d=%0d",
                     a, rsp_valid, rsp_data, (a == 0 ? 7 : 0));
         end
      end
   endtask

   task automatic test_illegal();
      step(1, 6, 10);
      step(9, 6, 3);
      n_checks++;
      if ({err, rsp_valid} !== 2'b10) begin
         n_fail++; $display("FAIL illegal_err got err=%b v=%b want err=1 v=0", err, rsp_valid);
      end
      step(0, 0, 0);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL illegal_pulse got %b want 0", err);
      end
      step(2, 6, 0);
      n_checks++;
      if ({rsp_valid, rsp_data} !== {1'b1, 4'd10}) begin
         n_fail++; $display("FAIL illegal_nochange got v=%b d=%0d want v=1 d=10", rsp_valid, rsp_data);
      end
   endtask

   task automatic test_reset_mid_sweep();
      step(4, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 15, 11);
      @(negedge clk);
      #2 rst = 1;
      #1;
      n_checks++;
      if ({rsp_valid, rsp_adr, rsp_data, rsp_carry, busy, err, drop_cnt} !== 19'd0) begin
         n_fail++;
         $display("FAIL async_reset got v=%b a=%0d d=%0d b=%b e=%b drop=%0d want all 0",
                  rsp_valid, rsp_adr, rsp_data, busy, err, drop_cnt);
      end
      @(negedge clk);
      rst = 0; cmd = 0;
      model_reset();
      step(2, 15, 0);
      n_checks++;
      if ({rsp_valid, rsp_data, busy, drop_cnt} !== {1'b1, 4'd0, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL post_reset_read got v=%b d=%0d b=%b drop=%0d want v=1 d=0 b=0 drop=0",
                  rsp_valid, rsp_data, busy, drop_cnt);
      end
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < 16; a++) step(1, a, $urandom_range(15));
      for (int a = 15; a >= 0; a--) begin
         step(2, a, 0);
         n_checks++;
         if ({rsp_valid, rsp_adr, rsp_data} !== {1'b1, 4'(a), 4'(mreg[a])}) begin
            n_fail++;
            $display("FAIL b2b_read[%0d] got v=%b a=%0d d=%0d want v=1 d=%0d",
                     a, rsp_valid, rsp_adr, rsp_data, mreg[a]);
         end
      end
   endtask

   task automatic test_saturation();
      for (int s = 0; s < 18; s++) begin
         step(4, 0, 0);
         for (int i = 0; i < 16; i++) step(1 + $urandom_range(2), $urandom_range(15), 1);
         n_checks++;
         if (drop_cnt !== 8'(mdrop)) begin
            n_fail++; $display("FAIL drop_sat[%0d] got %0d want %0d", s, drop_cnt, mdrop);
         end
      end
      n_checks++;
      if (drop_cnt !== 8'd255) begin
         n_fail++; $display("FAIL drop_sat_final got %0d want 255", drop_cnt);
      end
   endtask

   task automatic test_random();
      int c;
      for (int i = 0; i < 600; i++) begin
         c = $urandom_range(99);
         if (c < 20)      c = 1;
         else if (c < 40) c = 2;
         else if (c < 60) c = 3;
         else if (c < 64) c = 4;
         else if (c < 80) c = 0;
         else             c = $urandom_range(15);
         step(c, $urandom_range(15), $urandom_range(15));
         n_checks++;
         if ({rsp_valid, rsp_adr, rsp_data, rsp_carry, busy, err, drop_cnt} !==
             {exp_valid, exp_adr, exp_data, exp_carry, exp_busy, exp_err, 8'(mdrop)}) begin
            n_fail++;
            $display("FAIL random[%0d] cmd=%0d got v=%b a=%0d d=%0d c=%b b=%b e=%b drop=%0d want v=%b a=%0d d=%0d c=%b b=%b e=%b drop=%0d",
                     i, c, rsp_valid, rsp_adr, rsp_data, rsp_carry, busy, err, drop_cnt,
                     exp_valid, exp_adr, exp_data, exp_carry, exp_busy, exp_err, mdrop);
         end
      end
   endtask

   initial begin
      rst = 1; cmd = 0; adr = 0; data = 0;
      model_reset();
      test_reset();
      test_write_read();
      test_incr_carry();
      test_clear_drop();
      test_illegal();
      test_reset_mid_sweep();
      test_back_to_back();
      test_random();
      do_reset();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dut_cmd_proc.md
Name: dut_cmd_proc

Overview:
- Command-processing DUT that sits directly downstream of the DUT interface bundle. It consumes the slave-side cmd/adr/data nibbles on every rising clk edge.
- Executes register-file commands against a 16-entry x 4-bit array and returns registered responses.
- Serves as the design-under-test that the interface's covergroups observe. It has a multi-cycle clear sweep, a busy/drop policy and a 1-cycle response pipeline.

Parameters:
- ADR_W, 4, address width; register-file depth is 2**ADR_W.
- DATA_W, 4, data/register width.
- CMD_W, 4, command field width.
- DROP_W, 8, width of the saturating dropped-command counter.

Ports:
- clk  input  1  design clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- cmd  input  CMD_W  command opcode, sampled every posedge.
- adr  input  ADR_W  target register address.
- data  input  DATA_W  write/increment operand.
- rsp_valid  output  1  response strobe, one cycle wide.
- rsp_adr  output  ADR_W  address the response refers to.
- rsp_data  output  DATA_W  read value or post-increment value.
- rsp_carry  output  1  INCR overflow flag, valid with rsp_valid.
- busy  output  1  high while the CLEAR sweep is in progress.
- err  output  1  one-cycle pulse for an illegal opcode.
- drop_cnt  output  DROP_W  count of commands discarded while busy.

Behaviour:
- Reset (async assert, sync release in effect):
  - All 16 registers = 0; rsp_valid = 0; rsp_adr = 0; rsp_data = 0; rsp_carry = 0.
  - busy = 0; err = 0; drop_cnt = 0; FSM = IDLE.
  - Reset mid-sweep aborts the sweep immediately.
- Opcodes:
  - 0 NOP.
  - 1 WRITE: reg[adr] <= data.
  - 2 READ.
  - 3 INCR: reg[adr] <= reg[adr] + data, modulo 2**DATA_W.
  - 4 CLEAR.
  - 5-15 illegal.
- FSM states: IDLE, CLEAR.
- IDLE, per posedge:
  - Decode the sampled cmd; each command completes in that edge.
  - WRITE: updates the register; no response.
  - READ: next cycle rsp_valid = 1, rsp_adr = adr, rsp_data = reg[adr] as it was at the sampling edge, rsp_carry = 0.
  - INCR: register updated. Next cycle rsp_valid = 1, rsp_data = new value, rsp_carry = carry-out of the add.
  - Illegal opcode: err = 1 for exactly the next cycle; no state change.
  - CLEAR: go to CLEAR with sweep pointer = 0; busy = 1 from the next cycle.
- CLEAR:
  - Each cycle, reg[ptr] <= 0 and ptr increments.
  - After ptr = 2**ADR_W-1 is cleared, return to IDLE; busy falls in the same cycle.
  - busy is high for exactly 2**ADR_W cycles.
- Busy drop policy:
  - Any non-NOP cmd sampled while busy = 1 is discarded: no register change, no response, no err.
  - Each discarded command increments drop_cnt, which saturates at 2**DROP_W-1.
  - NOP while busy is not counted.
- Latency:
  - Response appears exactly 1 cycle after the command edge.
  - Back-to-back READs produce back-to-back rsp_valid pulses.
  - rsp_valid = 0 in any cycle without a qualifying command.
- Ordering:
  - WRITE then READ of the same adr on consecutive edges returns the new value.
  - A READ never observes a write issued on the same edge; this cannot occur with one command per cycle.
- Stability:
  - rsp_adr, rsp_data and rsp_carry hold their last values when rsp_valid = 0.
  - err is 0 whenever not pulsing.
- Unknown inputs: X on cmd during IDLE is treated as illegal (err pulse). Assertions flag this.

Decomposition:
- Shared package dut_pkg:
  - cmd_e enum (NOP, WRITE, READ, INCR, CLEAR).
  - ADR_W/DATA_W/CMD_W defaults.
  - rsp_t struct {adr, data, carry}.
- The same package is imported by the interface coverage classes so their bins use the same opcode names.
- One sub-module, dut_regfile:
  - 2**ADR_W x DATA_W array.
  - Async reset to 0.
  - One combinational read port and one write port with write-enable.
  - Includes a clear-by-pointer path.
- dut_cmd_proc holds the FSM, decode, response register and drop counter.

Test Plan:
- WRITE adr=3 data=9, then READ adr=3 → rsp_valid one cycle after the READ edge; rsp_adr = 3, rsp_data = 9, rsp_carry = 0.
- WRITE adr=5 data=14, then INCR adr=5 data=3 → rsp_data = 1, rsp_carry = 1; subsequent READ adr=5 returns 1.
- CLEAR, followed by 20 cycles of WRITE adr=0 data=7 → busy high for exactly 16 cycles; drop_cnt = 16 when busy falls. Remaining 4 WRITEs apply; READ adr=0 returns 7, all other addresses read 0.
- cmd = 9 in IDLE → err pulses for one cycle; no rsp_valid; register contents unchanged.
- Assert rst during cycle 6 of a CLEAR sweep → busy = 0 and all outputs at reset values asynchronously; after release, READ adr=15 returns 0 and drop_cnt = 0.
- Issue more than 255 non-NOP commands during repeated CLEAR sweeps → drop_cnt saturates at 255 and does not wrap.
